// File: rtl/parallel_add_pkg.sv
// Shared defaults and the per-lane add for parallel_add_pipe.
// Define SATURATE_EN to clamp lane sums instead of wrapping them.
package parallel_add_pkg;

  localparam int LANES_DEFAULT  = 4;
  localparam int PIXW_DEFAULT   = 8;
  localparam int STAGES_DEFAULT = 2;
  localparam int CNTW_DEFAULT   = 32;

  // Widest pixel the shared add function supports; callers zero-extend into it.
  localparam int MAX_PIXW = 32;
  localparam int SUMW     = MAX_PIXW + 1;

  // Operands hold a pixw-bit value zero-extended to MAX_PIXW, so the sum's
  // carry out of bit pixw-1 marks overflow of the real pixel width.
  function automatic logic [MAX_PIXW-1:0] add_lane(input logic [MAX_PIXW-1:0] a,
                                                   input logic [MAX_PIXW-1:0] b,
                                                   input int unsigned         pixw);
    logic [SUMW-1:0] sum;
    logic [SUMW-1:0] lim;
    logic [SUMW-1:0] res;
    lim = (SUMW'(1) << pixw) - SUMW'(1);
    sum = {1'b0, a} + {1'b0, b};
`ifdef SATURATE_EN
    res = (sum > lim) ? lim : sum;
`else
    res = sum & lim;
`endif
    return res[MAX_PIXW-1:0];
  endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// One elastic valid/ready register stage; loads whenever it is empty or
// its downstream neighbour is advancing.
module add_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         adv_in,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         adv_out
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  always_comb begin
    adv_out = !valid_q || adv_in;
    valid_d = valid_q;
    data_d  = data_q;
    if (adv_out) begin
      valid_d = in_valid;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/parallel_add_pipe.sv
// N-lane per-pixel adder behind a STAGES-deep elastic pipeline with a
// delivered-beat counter. Define SATURATE_EN for clamping lane sums.
module parallel_add_pipe
  import parallel_add_pkg::*;
#(
  parameter int LANES  = LANES_DEFAULT,
  parameter int PIXW   = PIXW_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT,
  parameter int CNTW   = CNTW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*PIXW-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [PIXW-1:0]       addend,
  output logic [LANES*PIXW-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [CNTW-1:0]       beat_count
);

  localparam int W = LANES * PIXW;

  logic [W-1:0]              sum_data;
  logic [STAGES:0]           adv;
  logic [STAGES-1:0]         stage_valid;
  logic [STAGES-1:0][W-1:0]  stage_data;
  logic [CNTW-1:0]           beat_count_q, beat_count_d;

  always_comb begin
    sum_data = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_data[i*PIXW +: PIXW] = PIXW'(add_lane(MAX_PIXW'(din[i*PIXW +: PIXW]),
                                                MAX_PIXW'(addend), PIXW));
    end
  end

  // The advance chain runs from dout_ready back to din_ready, so a full pipe
  // frees its input in the same cycle the consumer accepts.
  assign adv[STAGES] = dout_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         in_valid_k;
    logic [W-1:0] in_data_k;

    if (k == 0) begin : g_first
      assign in_valid_k = din_valid;
      assign in_data_k  = sum_data;
    end else begin : g_next
      assign in_valid_k = stage_valid[k-1];
      assign in_data_k  = stage_data[k-1];
    end

    add_pipe_stage #(
      .W(W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_k),
      .in_data  (in_data_k),
      .adv_in   (adv[k+1]),
      .valid    (stage_valid[k]),
      .data     (stage_data[k]),
      .adv_out  (adv[k])
    );
  end

  assign din_ready  = adv[0];
  assign dout_valid = stage_valid[STAGES-1];
  assign dout       = stage_data[STAGES-1];

  always_comb begin
    beat_count_d = beat_count_q;
    if (dout_valid && dout_ready) begin
      beat_count_d = beat_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_count_q <= '0;
    end else begin
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;

endmodule
